// File: rtl/dma_bus_arbiter_if.sv
// Bus-ownership signals between the CPU memory stage, the DMA engine and the arbiter.
// BR/BG: the DMA raises BR as a level and holds it for the whole transfer; BG is
// asserted only while the arbiter owns nothing else on the bus, and the DMA may
// drive d_memory only while BG=1. Dropping BR ends the tenure.
interface dma_bus_arbiter_if;
  logic       BR;
  logic       dma_end;
  logic       cpu_mem_busy;
  logic       BG;
  logic       cpu_stall;
  logic       dma_done_irq;
  logic [7:0] tenure;
  logic [7:0] xfer_count;
  logic       grant_timeout;
  logic [2:0] dbg_state;

  modport master (
    output BR, dma_end, cpu_mem_busy,
    input  BG, cpu_stall, dma_done_irq, tenure, xfer_count, grant_timeout, dbg_state
  );

  modport slave (
    input  BR, dma_end, cpu_mem_busy,
    output BG, cpu_stall, dma_done_irq, tenure, xfer_count, grant_timeout, dbg_state
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Arbitrates the d_memory bus between CPU and DMA: drains CPU accesses before
// granting, stalls the CPU during DMA tenure, and keeps tenure/transfer bookkeeping.
module dma_bus_arbiter #(
    parameter int MAX_GRANT = 16,
    parameter int MIN_GAP   = 1
) (
    input logic              CLK,
    input logic              reset,
    dma_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        GRANT    = 3'd2,
        RELEASE  = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam logic [7:0] MAX_GRANT_V = 8'(MAX_GRANT);
    localparam logic [3:0] GAP_INIT    = 4'(MIN_GAP);

    state_t     state;
    logic       bg;
    logic [3:0] gap;
    logic [7:0] tenure;
    logic [7:0] tenure_inc;
    logic [7:0] xfer_count;
    logic       grant_timeout;
    logic       dma_end_d;
    logic       dma_done_irq;

    always_comb begin
        tenure_inc = (tenure == 8'hFF) ? tenure : tenure + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            bg            <= 1'b0;
            gap           <= 4'd0;
            tenure        <= 8'd0;
            xfer_count    <= 8'd0;
            grant_timeout <= 1'b0;
            dma_end_d     <= 1'b0;
            dma_done_irq  <= 1'b0;
        end else begin
            dma_end_d    <= bus.dma_end;
            dma_done_irq <= bus.dma_end & ~dma_end_d;
            case (state)
                IDLE: begin
                    if (bus.BR) begin
                        if (!bus.cpu_mem_busy) begin
                            state  <= GRANT;
                            bg     <= 1'b1;
                            tenure <= 8'd0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.BR) begin
                        state <= IDLE;
                    end else if (!bus.cpu_mem_busy) begin
                        state  <= GRANT;
                        bg     <= 1'b1;
                        tenure <= 8'd0;
                    end
                end
                GRANT: begin
                    tenure <= tenure_inc;
                    if (tenure_inc == MAX_GRANT_V) grant_timeout <= 1'b1;
                    if (!bus.BR) begin
                        state      <= RELEASE;
                        bg         <= 1'b0;
                        xfer_count <= xfer_count + 8'd1;
                    end
                end
                RELEASE: begin
                    state <= COOLDOWN;
                    gap   <= GAP_INIT;
                end
                COOLDOWN: begin
                    // The IDLE cycle that follows counts toward the CPU's gap.
                    gap <= gap - 4'd1;
                    if (gap <= 4'd2) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    bg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BG            = bg;
    assign bus.cpu_stall     = (state == DRAIN) || (state == GRANT) || (state == RELEASE);
    assign bus.dma_done_irq  = dma_done_irq;
    assign bus.tenure        = tenure;
    assign bus.xfer_count    = xfer_count;
    assign bus.grant_timeout = grant_timeout;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: fixed vector table, corner-case sequences and
// randomized traffic checked against a counter-based reference model.
module tb_dma_bus_arbiter;
  localparam int MAX_GRANT = 16;
  localparam int MIN_GAP   = 3;
  localparam int CD        = (MIN_GAP > 1) ? MIN_GAP - 1 : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_bus_arbiter_if bus ();

  dma_bus_arbiter #(.MAX_GRANT(MAX_GRANT), .MIN_GAP(MIN_GAP)) dut (
    .CLK  (clk),
    .reset(rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model: grant flag plus a count of blocked cycles after release
  bit m_bg, m_stall, m_irq, m_timeout, m_prev_end;
  int m_tenure, m_xfer, m_gap;
  logic [19:0] exp_q[$];

  typedef struct {
    bit          br;
    bit          busy;
    bit          e;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [19:0] mk(bit bg, bit st, bit irq, bit to, int ten, int x);
    return {bg, st, irq, to, 8'(ten), 8'(x)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.BG, bus.cpu_stall, bus.dma_done_irq, bus.grant_timeout, bus.tenure, bus.xfer_count};
  endfunction

  function automatic logic [19:0] model_vec();
    return {m_bg, m_stall, m_irq, m_timeout, 8'(m_tenure), 8'(m_xfer)};
  endfunction

  task automatic model_edge(input bit r, input bit br, input bit busy, input bit e);
    if (r) begin
      m_bg = 0; m_stall = 0; m_irq = 0; m_timeout = 0; m_prev_end = 0;
      m_tenure = 0; m_xfer = 0; m_gap = 0;
    end else begin
      m_irq = e && !m_prev_end;
      m_prev_end = e;
      if (m_bg) begin
        m_tenure = (m_tenure < 255) ? m_tenure + 1 : 255;
        if (m_tenure == MAX_GRANT) m_timeout = 1;
        if (!br) begin
          m_bg   = 0;
          m_xfer = (m_xfer + 1) % 256;
          m_gap  = 1 + CD;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        m_stall = 0;
      end else if (br && !busy) begin
        m_bg = 1; m_stall = 1; m_tenure = 0;
      end else begin
        m_stall = br;
      end
    end
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got bg/st/irq/to=%b tenure=%0d xfer=%0d, want bg/st/irq/to=%b tenure=%0d xfer=%0d",
               name, act[19:16], act[15:8], act[7:0], exp[19:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit br, input bit busy, input bit e);
    logic [19:0] exp;
    bus.BR = br;
    bus.cpu_mem_busy = busy;
    bus.dma_end = e;
    @(posedge clk);
    model_edge(rst, br, busy, e);
    exp_q.push_back(model_vec());
    #1;
    exp = exp_q.pop_front();
    check("model", dut_vec(), exp);
  endtask

  task automatic do_reset(input bit br);
    rst = 1'b1;
    step(br, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    bit br, busy, e;
    bus.BR = 0; bus.cpu_mem_busy = 0; bus.dma_end = 0;

    // br busy end | bg stall irq timeout tenure xfer
    tbl[0]  = '{0, 0, 0, mk(0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 0, 0, mk(1, 1, 0, 0, 0, 0)};
    tbl[2]  = '{1, 0, 0, mk(1, 1, 0, 0, 1, 0)};
    tbl[3]  = '{1, 0, 0, mk(1, 1, 0, 0, 2, 0)};
    tbl[4]  = '{0, 0, 0, mk(0, 1, 0, 0, 3, 1)};
    tbl[5]  = '{1, 0, 0, mk(0, 0, 0, 0, 3, 1)};
    tbl[6]  = '{1, 0, 0, mk(0, 0, 0, 0, 3, 1)};
    tbl[7]  = '{1, 0, 0, mk(0, 0, 0, 0, 3, 1)};
    tbl[8]  = '{1, 1, 0, mk(0, 1, 0, 0, 3, 1)};
    tbl[9]  = '{1, 1, 0, mk(0, 1, 0, 0, 3, 1)};
    tbl[10] = '{1, 0, 0, mk(1, 1, 0, 0, 0, 1)};
    tbl[11] = '{0, 0, 1, mk(0, 1, 1, 0, 1, 2)};
    tbl[12] = '{0, 0, 1, mk(0, 0, 0, 0, 1, 2)};
    tbl[13] = '{0, 0, 0, mk(0, 0, 0, 0, 1, 2)};
    tbl[14] = '{0, 0, 0, mk(0, 0, 0, 0, 1, 2)};
    tbl[15] = '{1, 1, 0, mk(0, 1, 0, 0, 1, 2)};
    tbl[16] = '{0, 1, 0, mk(0, 0, 0, 0, 1, 2)};
    tbl[17] = '{0, 0, 0, mk(0, 0, 0, 0, 1, 2)};

    do_reset(0);
    check("reset_values", dut_vec(), 20'd0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].br, tbl[i].busy, tbl[i].e);
      check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // long tenure: 20 BG-high cycles, timeout raised and sticky
    do_reset(0);
    step(1, 0, 0);
    repeat (19) step(1, 0, 0);
    check_int("bg_held", int'(bus.BG), 1);
    step(0, 0, 0);
    check_int("tenure_20", int'(bus.tenure), 20);
    check_int("timeout_set", int'(bus.grant_timeout), 1);
    repeat (4) step(0, 0, 0);
    check_int("timeout_sticky", int'(bus.grant_timeout), 1);
    check_int("tenure_hold", int'(bus.tenure), 20);

    // end-of-transfer level held 5 cycles, then a second rise
    pulses = 0;
    repeat (5) begin step(0, 0, 1); pulses += int'(bus.dma_done_irq); end
    repeat (3) begin step(0, 0, 0); pulses += int'(bus.dma_done_irq); end
    repeat (2) begin step(0, 0, 1); pulses += int'(bus.dma_done_irq); end
    check_int("irq_pulses", pulses, 2);

    // 256 grants wrap the transfer counter
    do_reset(0);
    repeat (256) begin
      step(1, 0, 0);
      step(0, 0, 0);
      repeat (3) step(0, 0, 0);
    end
    check_int("xfer_wrap", int'(bus.xfer_count), 0);

    // reset while granted with BR still high
    step(1, 0, 0);
    step(1, 0, 0);
    check_int("granted_before_reset", int'(bus.BG), 1);
    do_reset(1);
    check("reset_mid_grant", dut_vec(), 20'd0);

    // randomized traffic
    br = 0; busy = 0; e = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) br = ~br;
      busy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) e = ~e;
      if ($urandom_range(0, 299) == 0) do_reset(br);
      else step(br, busy, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
